// File: rtl/pipearch_common.sv
// Shared types and constants for the pipearch BRAM-fed stages.
// The configreg layout here is common to the BRAM read and write stages.
package pipearch_common;

    typedef struct packed {
        logic [15:0] length;
        logic [15:0] offset;
    } bram_access_properties;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_ISSUE = 2'd1,
        STATE_DRAIN = 2'd2
    } t_readbram_state;

    localparam int CFG_OFFSET_LSB = 0;
    localparam int CFG_LENGTH_LSB = 16;

    function automatic bram_access_properties decode_configreg(input logic [31:0] cfg);
        bram_access_properties props;
        props.offset = cfg[CFG_OFFSET_LSB +: 16];
        props.length = cfg[CFG_LENGTH_LSB +: 16];
        return props;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for a valid bit, used to track BRAM read latency.
// Cleared by the synchronous active-low reset so in-flight reads are dropped.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
        end else begin
            r_shift[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign out_valid = r_shift[DEPTH-1];

endmodule

// File: rtl/read_bram.sv
// Streams a window of BRAM lines (offset/length from configreg) onto the write-side
// handshake. READ_LATENCY is expected in 1..4; dbg_state exposes the FSM state.
module read_bram
    import pipearch_common::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic [31:0]           configreg,
    output logic                  bram_re,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  out_we,
    output logic [DATA_WIDTH-1:0] out_wdata,
    input  logic                  out_almostfull,
    output logic                  busy,
    output logic                  op_done,
    output logic [1:0]            dbg_state
);

    // Handshake: out_we is a push with no ready; the consumer throttles only
    // through out_almostfull, which stops new reads but never gates out_we.

    t_readbram_state       r_state;
    bram_access_properties r_window;
    logic [15:0]           r_issued_cnt;
    logic [15:0]           r_recv_cnt;
    logic                  r_bram_re;
    logic [ADDR_WIDTH-1:0] r_bram_raddr;
    logic                  r_out_we;
    logic [DATA_WIDTH-1:0] r_out_wdata;
    logic                  r_busy;
    logic                  r_op_done;

    bram_access_properties w_cfg;
    logic                  w_tail;
    logic                  w_can_issue;
    logic                  w_last_issue;
    logic                  w_last_recv;

    assign w_cfg        = decode_configreg(configreg);
    assign w_can_issue  = !out_almostfull && (r_issued_cnt < r_window.length);
    // 17-bit compares keep length==0xFFFF from wrapping the counters.
    assign w_last_issue = ({1'b0, r_issued_cnt} + 17'd1) == {1'b0, r_window.length};
    assign w_last_recv  = ({1'b0, r_recv_cnt} + 17'd1) == {1'b0, r_window.length};

    valid_delay_line #(
        .DEPTH(READ_LATENCY)
    ) u_valid_delay (
        .clk      (clk),
        .reset    (reset),
        .in_valid (r_bram_re),
        .out_valid(w_tail)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= STATE_IDLE;
            r_window     <= '0;
            r_issued_cnt <= '0;
            r_recv_cnt   <= '0;
            r_bram_re    <= 1'b0;
            r_bram_raddr <= '0;
            r_out_we     <= 1'b0;
            r_busy       <= 1'b0;
            r_op_done    <= 1'b0;
        end else begin
            r_bram_re <= 1'b0;
            r_out_we  <= w_tail;
            r_op_done <= w_tail && w_last_recv;
            if (w_tail) begin
                r_recv_cnt <= r_recv_cnt + 16'd1;
            end

            case (r_state)
                STATE_IDLE: begin
                    r_busy <= 1'b0;
                    if (op_start) begin
                        r_window     <= w_cfg;
                        r_issued_cnt <= '0;
                        r_recv_cnt   <= '0;
                        if (w_cfg.length == 16'd0) begin
                            r_op_done <= 1'b1;
                        end else begin
                            r_state <= STATE_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                STATE_ISSUE: begin
                    r_busy <= 1'b1;
                    if (w_can_issue) begin
                        r_bram_re    <= 1'b1;
                        r_bram_raddr <= ADDR_WIDTH'(r_window.offset + r_issued_cnt);
                        r_issued_cnt <= r_issued_cnt + 16'd1;
                        if (w_last_issue) begin
                            r_state <= STATE_DRAIN;
                        end
                    end
                end

                STATE_DRAIN: begin
                    r_busy <= 1'b1;
                    if (r_recv_cnt == r_window.length) begin
                        r_state <= STATE_IDLE;
                    end
                end

                default: begin
                    r_state <= STATE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Data path carries no reset: it is qualified by out_we.
    always_ff @(posedge clk) begin
        r_out_wdata <= bram_rdata;
    end

    assign bram_re    = r_bram_re;
    assign bram_raddr = r_bram_raddr;
    assign out_we     = r_out_we;
    assign out_wdata  = r_out_wdata;
    assign busy       = r_busy;
    assign op_done    = r_op_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_read_bram.sv
// Directed bench for read_bram: BRAM model, window model with expected queues,
// per-cycle compare process and hand-computed timing expectations.
module tb_read_bram;

    localparam int DW = 512;
    localparam int AW = 10;
    localparam int RL = 2;

    logic          clk;
    logic          rst_n;
    logic          op_start;
    logic [31:0]   configreg;
    logic          bram_re;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_rdata;
    logic          out_we;
    logic [DW-1:0] out_wdata;
    logic          out_almostfull;
    logic          busy;
    logic          op_done;
    logic [1:0]    dbg_state;

    read_bram #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .op_start      (op_start),
        .configreg     (configreg),
        .bram_re       (bram_re),
        .bram_raddr    (bram_raddr),
        .bram_rdata    (bram_rdata),
        .out_we        (out_we),
        .out_wdata     (out_wdata),
        .out_almostfull(out_almostfull),
        .busy          (busy),
        .op_done       (op_done),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM model ----------------
    function automatic logic [DW-1:0] data_of(input int a);
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < DW / 16; w++) begin
            d[w*16 +: 16] = 16'(a ^ (w * 'h1111));
        end
        return d;
    endfunction

    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= data_of(int'(bram_raddr));
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bram_rdata = rd_pipe[RL-1];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] re_addrs[$];
    bit            m_active = 1'b0;

    int            re_count, we_count, done_count;
    int            first_re_cyc, first_we_cyc, done_cyc;
    logic [DW-1:0] first_wdata;
    logic          prev_af = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: got unexpected event at cycle %0d, required none", name, cyc);
    endtask

    task automatic clr_mon();
        re_count = 0; we_count = 0; done_count = 0;
        first_re_cyc = -1; first_we_cyc = -1; done_cyc = -1;
        first_wdata = '0;
        re_addrs.delete();
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic [AW-1:0] ea;
        if (bram_re === 1'b1) begin
            re_count++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
            re_addrs.push_back(bram_raddr);
            check("issue_gated_by_af", DW'(prev_af), DW'(1'b0));
            if (addr_q.size() == 0) fail("re_extra");
            else begin
                ea = addr_q.pop_front();
                check("raddr", DW'(bram_raddr), DW'(ea));
            end
        end
        if (out_we === 1'b1) begin
            we_count++;
            if (first_we_cyc < 0) begin
                first_we_cyc = cyc;
                first_wdata  = out_wdata;
            end
            if (exp_q.size() == 0) fail("we_extra");
            else begin
                e = exp_q.pop_front();
                check("wdata", out_wdata, e);
                check("op_done_on_last", DW'(op_done), DW'(exp_q.size() == 0));
                if (exp_q.size() == 0) m_active = 1'b0;
            end
        end
        if (op_done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        prev_af = out_almostfull;
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [31:0] cfg, output int t);
        int off, len, a;
        @(posedge clk); #1;
        op_start  = 1'b1;
        configreg = cfg;
        t = cyc;
        off = int'(cfg[15:0]);
        len = int'(cfg[31:16]);
        if (!m_active && len != 0) begin
            for (int i = 0; i < len; i++) begin
                a = (off + i) % (1 << AW);
                addr_q.push_back(AW'(a));
                exp_q.push_back(data_of(a));
            end
            m_active = 1'b1;
        end
        @(posedge clk); #1;
        op_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail("timeout_idle");
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bram_re"}, DW'(bram_re), DW'(1'b0));
        check({tag, "_out_we"}, DW'(out_we), DW'(1'b0));
        check({tag, "_busy"}, DW'(busy), DW'(1'b0));
        check({tag, "_op_done"}, DW'(op_done), DW'(1'b0));
        check({tag, "_state"}, DW'(dbg_state), DW'(2'd0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int t, c, w0;
        rst_n = 1'b0; op_start = 1'b0; configreg = '0; out_almostfull = 1'b0;
        clr_mon();
        idle_cycles(3);
        check_quiet("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic stream
        clr_mon();
        start_op({16'd8, 16'h0010}, t);
        check("basic_busy_T1", DW'(busy), DW'(1'b1));
        wait_idle(200, c);
        check("basic_busy_low", DW'(c), DW'(t + 14));
        check("basic_first_re", DW'(first_re_cyc), DW'(t + 2));
        check("basic_first_we", DW'(first_we_cyc), DW'(t + 5));
        check("basic_done_cyc", DW'(done_cyc), DW'(t + 12));
        check("basic_we_count", DW'(we_count), DW'(8));
        check("basic_done_count", DW'(done_count), DW'(1));
        check("basic_first_data", DW'(first_wdata[15:0]), DW'(16'h0010));
        check("basic_q_empty", DW'(exp_q.size()), DW'(0));

        // Zero length
        clr_mon();
        start_op(32'h0000_0020, t);
        check("zero_done_T1", DW'(op_done), DW'(1'b1));
        check("zero_busy_T1", DW'(busy), DW'(1'b0));
        idle_cycles(1);
        check("zero_done_T2", DW'(op_done), DW'(1'b0));
        idle_cycles(6);
        check("zero_re_count", DW'(re_count), DW'(0));
        check("zero_we_count", DW'(we_count), DW'(0));
        check("zero_done_count", DW'(done_count), DW'(1));

        // Back-pressure: almostfull high for cycles T+4..T+9
        clr_mon();
        start_op({16'd16, 16'h0080}, t);
        idle_cycles(3);
        out_almostfull = 1'b1;
        idle_cycles(6);
        check("bp_inflight_we", DW'(we_count), DW'(3));
        check("bp_issue_stalled", DW'(re_count), DW'(3));
        out_almostfull = 1'b0;
        wait_idle(300, c);
        check("bp_we_count", DW'(we_count), DW'(16));
        check("bp_re_count", DW'(re_count), DW'(16));
        check("bp_done_cyc", DW'(done_cyc), DW'(t + 26));
        check("bp_done_count", DW'(done_count), DW'(1));

        // Address wrap at 2^ADDR_WIDTH
        clr_mon();
        start_op({16'd4, 16'h03FE}, t);
        wait_idle(200, c);
        check("wrap_we_count", DW'(we_count), DW'(4));
        if (re_addrs.size() == 4) begin
            check("wrap_a0", DW'(re_addrs[0]), DW'(10'h3FE));
            check("wrap_a1", DW'(re_addrs[1]), DW'(10'h3FF));
            check("wrap_a2", DW'(re_addrs[2]), DW'(10'h000));
            check("wrap_a3", DW'(re_addrs[3]), DW'(10'h001));
        end else fail("wrap_addr_count");

        // 16-bit offset+count overflow still maps into the BRAM window
        clr_mon();
        start_op({16'd20, 16'hFFF0}, t);
        wait_idle(300, c);
        check("ovf_we_count", DW'(we_count), DW'(20));
        if (re_addrs.size() == 20) begin
            check("ovf_a15", DW'(re_addrs[15]), DW'(10'h3FF));
            check("ovf_a16", DW'(re_addrs[16]), DW'(10'h000));
        end else fail("ovf_addr_count");

        // Ignored start during ISSUE
        clr_mon();
        start_op({16'd6, 16'h0100}, t);
        idle_cycles(1);
        begin
            int t2;
            start_op({16'd3, 16'h0200}, t2);
        end
        wait_idle(200, c);
        check("ign_we_count", DW'(we_count), DW'(6));
        check("ign_done_count", DW'(done_count), DW'(1));
        check("ign_done_cyc", DW'(done_cyc), DW'(t + 10));
        check("ign_first_data", DW'(first_wdata[15:0]), DW'(16'h0100));

        // Reset mid-operation after the 5th out_we
        clr_mon();
        start_op({16'd32, 16'h0040}, t);
        for (int k = 0; k < 100 && we_count < 5; k++) begin
            @(posedge clk); #1;
        end
        if (we_count < 5) fail("rst_timeout_5th");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        m_active = 1'b0;
        check_quiet("midrst");
        w0 = we_count;
        idle_cycles(10);
        check("midrst_no_we", DW'(we_count), DW'(w0));
        clr_mon();
        start_op({16'd2, 16'h0050}, t);
        wait_idle(200, c);
        check("post_rst_we_count", DW'(we_count), DW'(2));
        check("post_rst_done_cyc", DW'(done_cyc), DW'(t + 6));
        check("post_rst_first_data", DW'(first_wdata[15:0]), DW'(16'h0050));

        // Reset and op_start on the same edge: reset wins
        clr_mon();
        @(posedge clk); #1;
        rst_n = 1'b0; op_start = 1'b1; configreg = {16'd4, 16'h0000};
        @(posedge clk); #1;
        rst_n = 1'b1; op_start = 1'b0;
        check_quiet("rst_start");
        idle_cycles(8);
        check("rst_start_re_count", DW'(re_count), DW'(0));
        check("rst_start_we_count", DW'(we_count), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
